// File: rtl/reg_file_arbiter.sv
// Round-robin arbiter sharing one 8x16 register file port between requesters A and B.
// One transaction in flight; writes complete in 2 cycles and reads in 3 cycles.
module reg_file_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ_A,
  input  logic              REQ_B,
  input  logic              WE_A,
  input  logic              WE_B,
  input  logic [ADDR_W-1:0] ADDR_A,
  input  logic [ADDR_W-1:0] ADDR_B,
  input  logic [DATA_W-1:0] WDATA_A,
  input  logic [DATA_W-1:0] WDATA_B,
  output logic              GNT_A,
  output logic              GNT_B,
  output logic              DONE_A,
  output logic              DONE_B,
  output logic [DATA_W-1:0] RDATA_A,
  output logic [DATA_W-1:0] RDATA_B,
  output logic              BUSY,
  output logic              RF_WrEn,
  output logic              RF_RdEn,
  output logic [ADDR_W-1:0] RF_Address,
  output logic [DATA_W-1:0] RF_WrData,
  input  logic [DATA_W-1:0] RF_RdData
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPT} state_t;

  state_t              state_q, state_d;
  logic                last_q, last_d;      // 1 = B was served last
  logic                win_q, win_d;        // 1 = B owns the transaction
  logic                we_q, we_d;
  logic                gnt_a_q, gnt_a_d, gnt_b_q, gnt_b_d;
  logic                done_a_q, done_a_d, done_b_q, done_b_d;
  logic                busy_q, busy_d;
  logic                wren_q, wren_d, rden_q, rden_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_a_q, rdata_a_d, rdata_b_q, rdata_b_d;
  logic                pick_b;

  // Next-state and registered-output computation for the arbitration FSM.
  // The RF address/data registers double as the latch for the winning command.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    win_d     = win_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_a_d = rdata_a_q;
    rdata_b_d = rdata_b_q;
    gnt_a_d   = 1'b0;
    gnt_b_d   = 1'b0;
    done_a_d  = 1'b0;
    done_b_d  = 1'b0;
    wren_d    = 1'b0;
    rden_d    = 1'b0;
    pick_b    = REQ_B && (!REQ_A || !last_q);
    case (state_q)
      IDLE: begin
        if (REQ_A || REQ_B) begin
          win_d   = pick_b;
          last_d  = pick_b;
          we_d    = pick_b ? WE_B : WE_A;
          addr_d  = pick_b ? ADDR_B : ADDR_A;
          wdata_d = pick_b ? WDATA_B : WDATA_A;
          gnt_a_d = !pick_b;
          gnt_b_d = pick_b;
          wren_d  = we_d;
          rden_d  = !we_d;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (we_q) begin
          done_a_d = !win_q;
          done_b_d = win_q;
          state_d  = IDLE;
        end else begin
          state_d = CAPT;
        end
      end
      CAPT: begin
        if (win_q) rdata_b_d = RF_RdData;
        else       rdata_a_d = RF_RdData;
        done_a_d = !win_q;
        done_b_d = win_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      win_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_a_q <= '0;
      rdata_b_q <= '0;
      gnt_a_q   <= 1'b0;
      gnt_b_q   <= 1'b0;
      done_a_q  <= 1'b0;
      done_b_q  <= 1'b0;
      busy_q    <= 1'b0;
      wren_q    <= 1'b0;
      rden_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      win_q     <= win_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_a_q <= rdata_a_d;
      rdata_b_q <= rdata_b_d;
      gnt_a_q   <= gnt_a_d;
      gnt_b_q   <= gnt_b_d;
      done_a_q  <= done_a_d;
      done_b_q  <= done_b_d;
      busy_q    <= busy_d;
      wren_q    <= wren_d;
      rden_q    <= rden_d;
    end
  end

  assign GNT_A      = gnt_a_q;
  assign GNT_B      = gnt_b_q;
  assign DONE_A     = done_a_q;
  assign DONE_B     = done_b_q;
  assign RDATA_A    = rdata_a_q;
  assign RDATA_B    = rdata_b_q;
  assign BUSY       = busy_q;
  assign RF_WrEn    = wren_q;
  assign RF_RdEn    = rden_q;
  assign RF_Address = addr_q;
  assign RF_WrData  = wdata_q;

endmodule

// File: tb/tb_reg_file_arbiter.sv
// Testbench for reg_file_arbiter with a behavioural 8x16 register file model.
module tb_reg_file_arbiter;

  logic        CLK, RST;
  logic        REQ_A, REQ_B, WE_A, WE_B;
  logic [2:0]  ADDR_A, ADDR_B;
  logic [15:0] WDATA_A, WDATA_B;
  logic        GNT_A, GNT_B, DONE_A, DONE_B, BUSY, RF_WrEn, RF_RdEn;
  logic [15:0] RDATA_A, RDATA_B, RF_WrData, RF_RdData;
  logic [2:0]  RF_Address;

  int errors = 0;
  int checks = 0;
  int overlap = 0;

  logic [15:0] mem [8];
  logic [15:0] pre_val [8];
  logic        preload;

  reg_file_arbiter #(.DATA_W(16), .ADDR_W(3)) dut (
    .CLK(CLK), .RST(RST),
    .REQ_A(REQ_A), .REQ_B(REQ_B), .WE_A(WE_A), .WE_B(WE_B),
    .ADDR_A(ADDR_A), .ADDR_B(ADDR_B), .WDATA_A(WDATA_A), .WDATA_B(WDATA_B),
    .GNT_A(GNT_A), .GNT_B(GNT_B), .DONE_A(DONE_A), .DONE_B(DONE_B),
    .RDATA_A(RDATA_A), .RDATA_B(RDATA_B), .BUSY(BUSY),
    .RF_WrEn(RF_WrEn), .RF_RdEn(RF_RdEn), .RF_Address(RF_Address),
    .RF_WrData(RF_WrData), .RF_RdData(RF_RdData)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Register file model: synchronous write, 1-cycle registered read.
  always @(posedge CLK) begin
    if (preload) begin
      for (int i = 0; i < 8; i++) mem[i] <= pre_val[i];
    end else if (RF_WrEn) begin
      mem[RF_Address] <= RF_WrData;
    end
    if (RF_RdEn) RF_RdData <= mem[RF_Address];
  end

  // Enable exclusivity monitor.
  always @(negedge CLK) if (RF_WrEn && RF_RdEn) overlap++;

  typedef struct {
    logic        rst;
    logic        ra, wa;
    logic [2:0]  aa;
    logic [15:0] da;
    logic        rb, wb;
    logic [2:0]  ab;
    logic [15:0] db;
    logic [6:0]  ctl;   // {GNT_A,GNT_B,DONE_A,DONE_B,BUSY,RF_WrEn,RF_RdEn}
    logic [2:0]  addr;
    logic [15:0] wd, rda, rdb;
  } vec_t;

  vec_t vecs [10];

  function automatic vec_t mk(logic rst, logic ra, logic wa, logic [2:0] aa, logic [15:0] da,
                              logic rb, logic wb, logic [2:0] ab, logic [15:0] db,
                              logic [6:0] ctl, logic [2:0] addr, logic [15:0] wd,
                              logic [15:0] rda, logic [15:0] rdb);
    vec_t v;
    v.rst = rst; v.ra = ra; v.wa = wa; v.aa = aa; v.da = da;
    v.rb = rb; v.wb = wb; v.ab = ab; v.db = db;
    v.ctl = ctl; v.addr = addr; v.wd = wd; v.rda = rda; v.rdb = rdb;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b0;
    step();
    step();
    RST = 1'b1;
    step();
  endtask

  initial begin
    int n, ga, gb, cyc, kg, kd, last_cyc;
    logic rb_bad;

    for (int i = 0; i < 8; i++) pre_val[i] = 16'h3C00 + 16'(i * 16'h0111);
    preload = 1'b0;
    RST = 1'b0;
    REQ_A = 0; REQ_B = 0; WE_A = 0; WE_B = 0;
    ADDR_A = '0; ADDR_B = '0; WDATA_A = '0; WDATA_B = '0;

    // Reset, then A writes BEEF to reg 5 and B reads it back.
    vecs[0] = mk(0, 0,0,0,16'h0, 0,0,0,16'h0, 7'b0000000, 0, 16'h0,    16'h0, 16'h0);
    vecs[1] = mk(0, 0,0,0,16'h0, 0,0,0,16'h0, 7'b0000000, 0, 16'h0,    16'h0, 16'h0);
    vecs[2] = mk(1, 0,0,0,16'h0, 0,0,0,16'h0, 7'b0000000, 0, 16'h0,    16'h0, 16'h0);
    vecs[3] = mk(1, 0,0,0,16'h0, 0,0,0,16'h0, 7'b0000000, 0, 16'h0,    16'h0, 16'h0);
    vecs[4] = mk(1, 1,1,5,16'hBEEF, 0,0,0,16'h0, 7'b1000110, 5, 16'hBEEF, 16'h0, 16'h0);
    vecs[5] = mk(1, 0,0,0,16'h0, 0,0,0,16'h0, 7'b0010000, 5, 16'hBEEF, 16'h0, 16'h0);
    vecs[6] = mk(1, 0,0,0,16'h0, 1,0,5,16'h0, 7'b0100101, 5, 16'h0,    16'h0, 16'h0);
    vecs[7] = mk(1, 0,0,0,16'h0, 0,0,0,16'h0, 7'b0000100, 5, 16'h0,    16'h0, 16'h0);
    vecs[8] = mk(1, 0,0,0,16'h0, 0,0,0,16'h0, 7'b0001000, 5, 16'h0,    16'h0, 16'hBEEF);
    vecs[9] = mk(1, 0,0,0,16'h0, 0,0,0,16'h0, 7'b0000000, 5, 16'h0,    16'h0, 16'hBEEF);

    for (int i = 0; i < 10; i++) begin
      RST = vecs[i].rst;
      REQ_A = vecs[i].ra; WE_A = vecs[i].wa; ADDR_A = vecs[i].aa; WDATA_A = vecs[i].da;
      REQ_B = vecs[i].rb; WE_B = vecs[i].wb; ADDR_B = vecs[i].ab; WDATA_B = vecs[i].db;
      step();
      check($sformatf("vec%0d", i),
            64'({GNT_A, GNT_B, DONE_A, DONE_B, BUSY, RF_WrEn, RF_RdEn,
                 RF_Address, RF_WrData, RDATA_A, RDATA_B}),
            64'({vecs[i].ctl, vecs[i].addr, vecs[i].wd, vecs[i].rda, vecs[i].rdb}));
    end

    // Both sides hold REQ: A writes regs 1,3,5 and B writes 2,4,6; grants must alternate.
    REQ_A = 1; WE_A = 1; ADDR_A = 3'd1; WDATA_A = 16'hA001;
    REQ_B = 1; WE_B = 1; ADDR_B = 3'd2; WDATA_B = 16'hA002;
    n = 0; ga = 0; gb = 0; cyc = 0;
    while (cyc < 40 && (ga < 3 || gb < 3)) begin
      step();
      cyc++;
      if (GNT_A || GNT_B) begin
        check($sformatf("t3_grant%0d", n), 64'({GNT_A, GNT_B}), (n % 2 == 0) ? 64'd2 : 64'd1);
        n++;
      end
      if (GNT_A) begin
        ga++;
        if (ga < 3) begin
          ADDR_A = 3'(2 * ga + 1);
          WDATA_A = 16'hA000 | 16'(2 * ga + 1);
        end else REQ_A = 0;
      end
      if (GNT_B) begin
        gb++;
        if (gb < 3) begin
          ADDR_B = 3'(2 * gb + 2);
          WDATA_B = 16'hA000 | 16'(2 * gb + 2);
        end else REQ_B = 0;
      end
    end
    check("t3_grant_count", 64'(n), 64'd6);
    step();
    step();
    for (int i = 1; i <= 6; i++)
      check($sformatf("t3_mem%0d", i), 64'(mem[i]), 64'(16'hA000 | 16'(i)));
    check("t3_no_overlap", 64'(overlap), 64'd0);

    // Reset (RF kept, then preloaded), A alone reads regs 0..7 back to back.
    preload = 1'b1;
    RST = 1'b0;
    step();
    preload = 1'b0;
    step();
    RST = 1'b1;
    step();
    check("t4_reset_rdata_b", 64'(RDATA_B), 64'd0);
    REQ_A = 1; WE_A = 0; ADDR_A = 3'd0;
    kg = 0; kd = 0; cyc = 0; last_cyc = 0; rb_bad = 1'b0;
    while (cyc < 60 && kd < 8) begin
      step();
      cyc++;
      if (RDATA_B !== 16'h0 || GNT_B || DONE_B) rb_bad = 1'b1;
      if (GNT_A) begin
        kg++;
        if (kg < 8) ADDR_A = 3'(kg);
        else REQ_A = 0;
      end
      if (DONE_A) begin
        check($sformatf("t4_rdata%0d", kd), 64'(RDATA_A), 64'(pre_val[kd]));
        if (kd > 0) check($sformatf("t4_gap%0d", kd), 64'(cyc - last_cyc), 64'd3);
        last_cyc = cyc;
        kd++;
      end
    end
    check("t4_done_count", 64'(kd), 64'd8);
    check("t4_side_b_quiet", 64'(rb_bad), 64'd0);

    // Reset while the read is in CAPT: no DONE, RDATA stays 0, next tie goes to A.
    do_reset();
    REQ_A = 1; WE_A = 0; ADDR_A = 3'd3;
    step();
    check("t5_gnt", 64'({GNT_A, RF_RdEn}), 64'd3);
    REQ_A = 0;
    step();
    check("t5_capt", 64'({BUSY, RF_RdEn, DONE_A}), 64'b100);
    RST = 1'b0;
    step();
    check("t5_in_reset", 64'({DONE_A, DONE_B, BUSY, GNT_A, RDATA_A}), 64'd0);
    RST = 1'b1;
    step();
    check("t5_after_reset", 64'({DONE_A, BUSY, RDATA_A}), 64'd0);
    REQ_A = 1; WE_A = 1; ADDR_A = 3'd0; WDATA_A = 16'h0A0A;
    REQ_B = 1; WE_B = 1; ADDR_B = 3'd1; WDATA_B = 16'h0B0B;
    step();
    check("t5_tie_to_a", 64'({GNT_A, GNT_B}), 64'b10);
    REQ_A = 0; REQ_B = 0;
    step();
    check("t5_done_a", 64'({DONE_A, DONE_B}), 64'b10);
    step();

    // REQ_B pulsed during A's ISSUE is dropped; REQ_B held into IDLE is served.
    REQ_A = 1; WE_A = 1; ADDR_A = 3'd7; WDATA_A = 16'h7777;
    step();
    check("t6_gnt_a1", 64'(GNT_A), 64'd1);
    REQ_A = 0; REQ_B = 1; WE_B = 0; ADDR_B = 3'd7;
    step();
    check("t6_pulse_ignored", 64'({DONE_A, GNT_B}), 64'b10);
    REQ_B = 0;
    step();
    check("t6_idle1", 64'({GNT_B, BUSY}), 64'd0);
    step();
    check("t6_idle2", 64'({GNT_B, BUSY}), 64'd0);
    REQ_A = 1; WDATA_A = 16'h6E6E;
    step();
    check("t6_gnt_a2", 64'(GNT_A), 64'd1);
    REQ_A = 0; REQ_B = 1;
    step();
    check("t6_held_issue", 64'({DONE_A, GNT_B}), 64'b10);
    step();
    check("t6_gnt_b", 64'({GNT_B, RF_RdEn, RF_Address}), 64'({2'b11, 3'd7}));
    REQ_B = 0;
    step();
    step();
    check("t6_done_b", 64'({DONE_B, RDATA_B}), 64'({1'b1, 16'h6E6E}));
    check("no_overlap", 64'(overlap), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
